// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 valid/ready stream demux.
// One output stage per port, plus per-port handshake counters.
module demux1to2_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [WIDTH-1:0] r_d0;
  logic [WIDTH-1:0] r_d1;
  logic             r_v0;
  logic             r_v1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_can0;
  logic w_can1;
  logic w_acc;
  logic w_ld0;
  logic w_ld1;
  logic w_hs0;
  logic w_hs1;

  assign w_can0 = !r_v0 | out0_ready;
  assign w_can1 = !r_v1 | out1_ready;

  // Gated by rst_n so the source sees back-pressure while held in reset
  assign in_ready = rst_n & (in_sel ? w_can1 : w_can0);

  assign w_acc = in_valid & in_ready;
  assign w_ld0 = w_acc & !in_sel;
  assign w_ld1 = w_acc & in_sel;
  assign w_hs0 = r_v0 & out0_ready;
  assign w_hs1 = r_v1 & out1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d0 <= '0;
      r_v0 <= 1'b0;
    end else if (w_ld0) begin
      r_d0 <= in_data;
      r_v0 <= 1'b1;
    end else if (w_hs0) begin
      r_v0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= '0;
      r_v1 <= 1'b0;
    end else if (w_ld1) begin
      r_d1 <= in_data;
      r_v1 <= 1'b1;
    end else if (w_hs1) begin
      r_v1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_hs0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_hs1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign out0_data  = r_d0;
  assign out0_valid = r_v0;
  assign out1_data  = r_d1;
  assign out1_valid = r_v1;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed testbench for demux1to2_stream.
// Counters built at 4 bits so wrap is reachable quickly.
module tb_demux1to2_stream;

  localparam int W = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cnt_clr;
  logic [W-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [W-1:0]  out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux1to2_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_clr(cnt_clr),
    .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cnt_clr = 1'b0;
    in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    step(); step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if ({out0_valid, out1_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid got=%b%b exp=00", out0_valid, out1_valid);
    end
    checks++;
    if (out0_data !== 32'h0 || out1_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got=%h/%h exp=0/0", out0_data, out1_data);
    end
    checks++;
    if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_sel = 1'b0;
    in_data = 32'h0000_00A5; out0_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_in_ready got=%b exp=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hA5) begin
      errors++;
      $display("FAIL basic_out0 got=%b/%h exp=1/a5", out0_valid, out0_data);
    end
    checks++;
    if (out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_out1_valid got=%b exp=0", out1_valid);
    end
    step();
    checks++;
    if (cnt0 !== 4'd1 || out0_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_cnt0 got=%0d/%b exp=1/0", cnt0, out0_valid);
    end
  endtask

  task automatic test_stream();
    out1_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_sel = 1'b1; in_data = W'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready);
      end
      step();
      checks++;
      if (out1_valid !== 1'b1 || out1_data !== W'(i)) begin
        errors++;
        $display("FAIL stream_out1 i=%0d got=%b/%h exp=1/%h",
                 i, out1_valid, out1_data, W'(i));
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (cnt1 !== 4'd8 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_cnt1 got=%0d/%b exp=8/0", cnt1, out1_valid);
    end
  endtask

  task automatic test_stall_isolation();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
    step();
    in_data = 32'h0BAD_0BAD;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready got=%b exp=0", in_ready);
    end
    step();
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL stall_hold got=%b/%h exp=1/deadbeef", out0_valid, out0_data);
    end
    in_sel = 1'b1; in_data = 32'h1234; out1_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL iso_in_ready got=%b exp=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h1234) begin
      errors++;
      $display("FAIL iso_out1 got=%b/%h exp=1/1234", out1_valid, out1_data);
    end
    checks++;
    if (out0_data !== 32'hDEAD_BEEF || out0_valid !== 1'b1) begin
      errors++;
      $display("FAIL iso_out0 got=%b/%h exp=1/deadbeef", out0_valid, out0_data);
    end
  endtask

  task automatic test_drain_refill();
    out0_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h55;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL refill_in_ready got=%b exp=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 32'h55) begin
      errors++;
      $display("FAIL refill_out0 got=%b/%h exp=1/55", out0_valid, out0_data);
    end
    checks++;
    if (cnt0 !== 4'd2 || cnt1 !== 4'd9) begin
      errors++;
      $display("FAIL refill_cnt got=%0d/%0d exp=2/9", cnt0, cnt1);
    end
    step();
    checks++;
    if (cnt0 !== 4'd3 || out0_valid !== 1'b0) begin
      errors++;
      $display("FAIL refill_drain got=%0d/%b exp=3/0", cnt0, out0_valid);
    end
  endtask

  task automatic test_counter();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL clr_cnt got=%0d/%0d exp=0/0", cnt0, cnt1);
    end
    out1_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_sel = 1'b1; in_data = W'(100 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (cnt1 !== 4'd1) begin
      errors++;
      $display("FAIL wrap_cnt1 got=%0d exp=1", cnt1);
    end
    in_valid = 1'b1; in_data = 32'h77;
    step();
    in_valid = 1'b0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (cnt1 !== 4'd0 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_prio got=%0d/%b exp=0/0", cnt1, out1_valid);
    end
  endtask

  task automatic test_reset_mid();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAA;
    step();
    in_sel = 1'b1; in_data = 32'hBB;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1 || cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL mid_pre got=%b%b/%0d exp=11/0", out0_valid, out1_valid, cnt1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got=%b%b/%b exp=00/0",
               out0_valid, out1_valid, in_ready);
    end
    checks++;
    if (out0_data !== 32'h0 || out1_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_data got=%h/%h exp=0/0", out0_data, out1_data);
    end
    step();
    rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    step(); step();
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 ||
        cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL mid_after got=%b%b/%0d/%0d exp=00/0/0",
               out0_valid, out1_valid, cnt0, cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_stall_isolation();
    test_drain_refill();
    test_counter();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
